// File: rtl/magic_mem_pkg.sv
// Shared types for the multi-port behavioural memory: port FSM states, request
// record and latency counter width.
package magic_mem_pkg;

  localparam int LAT_CNT_W      = 4;
  localparam int MEM_DATA_WIDTH = 16;
  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_BYTES      = MEM_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } port_state_e;

  typedef struct packed {
    logic                      rd;
    logic                      wr;
    logic [MEM_BYTES-1:0]      wmask;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/magic_mem_port_ctrl.sv
// Per-port sequencer: IDLE -> WAIT -> RESP with a latency counter and request latch.
// Optional request-stability checker under MAGIC_MEM_PROTOCOL_CHECK_EN.
module magic_mem_port_ctrl
  import magic_mem_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  ADDR_WIDTH = 16,
  parameter int  LATENCY    = 1,
  localparam int BYTES      = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_i,
  input  logic                  wr_i,
  input  logic [BYTES-1:0]      wmask_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output port_state_e           state_o,
  output logic                  commit_o,
  output logic                  rd_o,
  output logic                  wr_o,
  output logic [BYTES-1:0]      wmask_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  err_o
);

  // Handshake: a request (rd_i|wr_i) is accepted on the first edge it is seen
  // high in IDLE; the requester holds it unchanged until the cycle resp is high.
  // commit_o marks the edge that enters RESP, where the access takes effect.
  localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(LATENCY - 1);

  port_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  rd_q, wr_q;
  logic [BYTES-1:0]      wmask_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  req_in;
  logic                  use_live;

  assign req_in = rd_i | wr_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d  = RESP;
            commit_o = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_CNT_W'(1)) begin
          state_d  = RESP;
          commit_o = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wmask_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_in) begin
        rd_q    <= rd_i;
        wr_q    <= wr_i;
        wmask_q <= wmask_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // With single-cycle latency the commit edge is also the accept edge, so the
  // live request is forwarded instead of the (not yet written) latch.
  assign use_live = (state_q == IDLE);
  assign rd_o     = use_live ? rd_i    : rd_q;
  assign wr_o     = use_live ? wr_i    : wr_q;
  assign wmask_o  = use_live ? wmask_i : wmask_q;
  assign addr_o   = use_live ? addr_i  : addr_q;
  assign wdata_o  = use_live ? wdata_i : wdata_q;
  assign state_o  = state_q;

`ifdef MAGIC_MEM_PROTOCOL_CHECK_EN
  logic err_q;
  logic req_changed;

  assign req_changed = (rd_i != rd_q) || (wr_i != wr_q) || (wmask_i != wmask_q) ||
                       (addr_i != addr_q) || (wdata_i != wdata_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((state_q == WAIT || state_q == RESP) && req_changed) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/magic_memory_mp.sv
// Multi-port behavioural memory with per-port fixed latency and byte-lane writes.
// Define MAGIC_MEM_PROTOCOL_CHECK_EN to enable the sticky proto_err checker.
module magic_memory_mp
  import magic_mem_pkg::*;
#(
  parameter int  NUM_PORTS  = 2,
  parameter int  DATA_WIDTH = 16,
  parameter int  ADDR_WIDTH = 16,
  parameter int  LATENCY    = 1,
  localparam int BYTES      = DATA_WIDTH / 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 read,
  input  logic [NUM_PORTS-1:0]                 write,
  input  logic [NUM_PORTS-1:0][BYTES-1:0]      wmask,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] address,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata,
  output logic [NUM_PORTS-1:0]                 resp,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata,
  output logic [NUM_PORTS-1:0]                 proto_err
);

  localparam int OFF   = $clog2(BYTES);
  localparam int WIW   = ADDR_WIDTH - OFF;
  localparam int WORDS = 1 << WIW;

  logic [DATA_WIDTH-1:0]                 mem_q [WORDS];
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_q;
  port_state_e                           st [NUM_PORTS];
  logic [NUM_PORTS-1:0]                  commit, c_rd, c_wr;
  logic [NUM_PORTS-1:0][BYTES-1:0]       c_mask;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  c_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  c_wdata;
  logic [NUM_PORTS-1:0][WIW-1:0]         c_idx;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    magic_mem_port_ctrl #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LATENCY    (LATENCY)
    ) u_ctrl (
      .clk_i    (clk),
      .rst_i    (rst),
      .rd_i     (read[p]),
      .wr_i     (write[p]),
      .wmask_i  (wmask[p]),
      .addr_i   (address[p]),
      .wdata_i  (wdata[p]),
      .state_o  (st[p]),
      .commit_o (commit[p]),
      .rd_o     (c_rd[p]),
      .wr_o     (c_wr[p]),
      .wmask_o  (c_mask[p]),
      .addr_o   (c_addr[p]),
      .wdata_o  (c_wdata[p]),
      .err_o    (proto_err[p])
    );
    assign c_idx[p] = WIW'(c_addr[p] >> OFF);
    assign resp[p]  = (st[p] == RESP);
  end

  // Walk ports from highest to lowest index so the lowest-index writer of a
  // byte lands last and wins; the array is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (commit[p] && c_wr[p]) begin
          for (int b = 0; b < BYTES; b++) begin
            if (c_mask[p][b]) mem_q[c_idx[p]][b*8 +: 8] <= c_wdata[p][b*8 +: 8];
          end
        end
      end
    end
  end

  // Reads sample the array before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (commit[p] && c_rd[p]) rdata_q[p] <= mem_q[c_idx[p]];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_magic_memory_mp.sv
// Bench for magic_memory_mp: three instances (default, 3-port/32-bit/latency 4,
// latency 3) checked each cycle against a byte-level memory model plus directed literals.
module tb_magic_memory_mp;

  localparam int ND = 3;
  localparam int NP  [ND] = '{2, 3, 2};
  localparam int LAT [ND] = '{1, 4, 3};
  localparam int NB  [ND] = '{2, 4, 2};
`ifdef MAGIC_MEM_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // unified stimulus / observation view, indexed [instance][port]
  logic        rd_v [ND][8];
  logic        wr_v [ND][8];
  logic [3:0]  wm_v [ND][8];
  logic [15:0] ad_v [ND][8];
  logic [31:0] wd_v [ND][8];
  logic        rs_v [ND][8];
  logic [31:0] rdv  [ND][8];
  logic        pe_v [ND][8];

  logic [1:0]       a_rd, a_wr, a_resp, a_err;
  logic [1:0][1:0]  a_wm;
  logic [1:0][15:0] a_ad, a_wd, a_rdata;
  logic [2:0]       b_rd, b_wr, b_resp, b_err;
  logic [2:0][3:0]  b_wm;
  logic [2:0][15:0] b_ad;
  logic [2:0][31:0] b_wd, b_rdata;
  logic [1:0]       c_rd, c_wr, c_resp, c_err;
  logic [1:0][1:0]  c_wm;
  logic [1:0][15:0] c_ad, c_wd, c_rdata;

  magic_memory_mp u_a (
    .clk(clk), .rst(rst), .read(a_rd), .write(a_wr), .wmask(a_wm), .address(a_ad),
    .wdata(a_wd), .resp(a_resp), .rdata(a_rdata), .proto_err(a_err));

  magic_memory_mp #(.NUM_PORTS(3), .DATA_WIDTH(32), .ADDR_WIDTH(16), .LATENCY(4)) u_b (
    .clk(clk), .rst(rst), .read(b_rd), .write(b_wr), .wmask(b_wm), .address(b_ad),
    .wdata(b_wd), .resp(b_resp), .rdata(b_rdata), .proto_err(b_err));

  magic_memory_mp #(.NUM_PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(16), .LATENCY(3)) u_c (
    .clk(clk), .rst(rst), .read(c_rd), .write(c_wr), .wmask(c_wm), .address(c_ad),
    .wdata(c_wd), .resp(c_resp), .rdata(c_rdata), .proto_err(c_err));

  always_comb begin
    a_rd = '0; a_wr = '0; a_wm = '0; a_ad = '0; a_wd = '0;
    b_rd = '0; b_wr = '0; b_wm = '0; b_ad = '0; b_wd = '0;
    c_rd = '0; c_wr = '0; c_wm = '0; c_ad = '0; c_wd = '0;
    for (int p = 0; p < 2; p++) begin
      a_rd[p] = rd_v[0][p]; a_wr[p] = wr_v[0][p]; a_wm[p] = wm_v[0][p][1:0];
      a_ad[p] = ad_v[0][p]; a_wd[p] = wd_v[0][p][15:0];
      c_rd[p] = rd_v[2][p]; c_wr[p] = wr_v[2][p]; c_wm[p] = wm_v[2][p][1:0];
      c_ad[p] = ad_v[2][p]; c_wd[p] = wd_v[2][p][15:0];
    end
    for (int p = 0; p < 3; p++) begin
      b_rd[p] = rd_v[1][p]; b_wr[p] = wr_v[1][p]; b_wm[p] = wm_v[1][p];
      b_ad[p] = ad_v[1][p]; b_wd[p] = wd_v[1][p];
    end
  end

  always_comb begin
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < 8; p++) begin
        rs_v[d][p] = 1'b0; rdv[d][p] = '0; pe_v[d][p] = 1'b0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      rs_v[0][p] = a_resp[p]; rdv[0][p] = 32'(a_rdata[p]); pe_v[0][p] = a_err[p];
      rs_v[2][p] = c_resp[p]; rdv[2][p] = 32'(c_rdata[p]); pe_v[2][p] = c_err[p];
    end
    for (int p = 0; p < 3; p++) begin
      rs_v[1][p] = b_resp[p]; rdv[1][p] = b_rdata[p]; pe_v[1][p] = b_err[p];
    end
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0]  mm [int];
  int          due  [ND][8];
  int          acc  [ND][8];
  logic        lrd  [ND][8];
  logic        lwr  [ND][8];
  logic [3:0]  lwm  [ND][8];
  logic [15:0] lad  [ND][8];
  logic [31:0] lwd  [ND][8];
  logic [31:0] m_rdata [ND][8];
  logic        m_err   [ND][8];
  bit          seen_rst = 1'b0;

  function automatic int key(int d, logic [15:0] a, int b);
    int ai;
    ai = int'(a);
    return d * 131072 + (ai - ai % NB[d]) + b;
  endfunction

  function automatic logic [31:0] model_word(int d, logic [15:0] a);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < NB[d]; b++) begin
      if (mm.exists(key(d, a, b))) w[b*8 +: 8] = mm[key(d, a, b)];
    end
    return w;
  endfunction

  initial begin
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < 8; p++) begin
        due[d][p] = -1; acc[d][p] = -1; lrd[d][p] = 0; lwr[d][p] = 0;
        lwm[d][p] = '0; lad[d][p] = '0; lwd[d][p] = '0;
        m_rdata[d][p] = '0; m_err[d][p] = 1'b0;
      end
    end
  end

  // Cycle c: accesses due now have completed on the edge entering c, reads
  // before any same-cycle write; the request visible in c is accepted for c+LAT.
  always @(negedge clk) begin : compare
    int c;
    c = cyc;
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < NP[d]; p++)
        if (due[d][p] == c && lrd[d][p]) m_rdata[d][p] = model_word(d, lad[d][p]);
    for (int d = 0; d < ND; d++)
      for (int p = NP[d] - 1; p >= 0; p--)
        if (due[d][p] == c && lwr[d][p])
          for (int b = 0; b < NB[d]; b++)
            if (lwm[d][p][b]) mm[key(d, lad[d][p], b)] = lwd[d][p][b*8 +: 8];
    if (seen_rst) begin
      for (int d = 0; d < ND; d++) begin
        for (int p = 0; p < NP[d]; p++) begin
          chk($sformatf("resp d%0d p%0d c%0d", d, p, c), 32'(rs_v[d][p]), 32'(due[d][p] == c));
          chk($sformatf("rdata d%0d p%0d c%0d", d, p, c), rdv[d][p], m_rdata[d][p]);
          chk($sformatf("proto_err d%0d p%0d c%0d", d, p, c), 32'(pe_v[d][p]), 32'(m_err[d][p]));
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < NP[d]; p++) begin
        if (rst) begin
          due[d][p] = -1; acc[d][p] = -1; m_rdata[d][p] = '0; m_err[d][p] = 1'b0;
        end else begin
          if (CHK && acc[d][p] < c && c <= due[d][p] &&
              (rd_v[d][p] != lrd[d][p] || wr_v[d][p] != lwr[d][p] || wm_v[d][p] != lwm[d][p] ||
               ad_v[d][p] != lad[d][p] || wd_v[d][p] != lwd[d][p]))
            m_err[d][p] = 1'b1;
          if (c > due[d][p] && (rd_v[d][p] || wr_v[d][p])) begin
            lrd[d][p] = rd_v[d][p]; lwr[d][p] = wr_v[d][p]; lwm[d][p] = wm_v[d][p];
            lad[d][p] = ad_v[d][p]; lwd[d][p] = wd_v[d][p];
            acc[d][p] = c; due[d][p] = c + LAT[d];
          end
        end
      end
    end
    if (rst) seen_rst = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d, input int p, input bit r, input bit w,
                       input logic [15:0] a, input logic [31:0] wd, input logic [3:0] m);
    rd_v[d][p] = r; wr_v[d][p] = w; ad_v[d][p] = a; wd_v[d][p] = wd; wm_v[d][p] = m;
  endtask

  task automatic stop(input int d, input int p);
    rd_v[d][p] = 1'b0; wr_v[d][p] = 1'b0;
  endtask

  task automatic wait_resp(input int d, input int p, output logic [31:0] data);
    int n;
    n = 0;
    @(negedge clk);
    while (!rs_v[d][p] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rs_v[d][p]) chk($sformatf("timeout d%0d p%0d", d, p), 32'(rs_v[d][p]), 32'd1);
    data = rdv[d][p];
  endtask

  task automatic access(input int d, input int p, input bit r, input bit w,
                        input logic [15:0] a, input logic [31:0] wd, input logic [3:0] m,
                        output logic [31:0] data);
    sync();
    start(d, p, r, w, a, wd, m);
    wait_resp(d, p, data);
    sync();
    stop(d, p);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] dat;
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < 8; p++) begin
        rd_v[d][p] = 0; wr_v[d][p] = 0; wm_v[d][p] = '0; ad_v[d][p] = '0; wd_v[d][p] = '0;
      end
    rst = 1'b1;
    sync();
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("reset resp0", 32'(a_resp[0]), 32'd0);
    chk("reset rdata0", 32'(a_rdata[0]), 32'd0);
    chk("reset proto_err0", 32'(a_err[0]), 32'd0);

    // 1: single write, one-cycle latency, then readback
    sync();
    start(0, 0, 0, 1, 16'h0010, 32'hBEEF, 4'b0011);
    @(negedge clk);
    chk("t1 resp same cycle", 32'(a_resp[0]), 32'd0);
    @(negedge clk);
    chk("t1 resp next cycle", 32'(a_resp[0]), 32'd1);
    sync();
    stop(0, 0);
    access(0, 0, 1, 0, 16'h0010, 32'h0, 4'b0, dat);
    chk("t1 readback", dat, 32'h0000BEEF);

    // 2: partial byte write
    access(0, 0, 0, 1, 16'h0020, 32'h1234, 4'b0011, dat);
    access(0, 0, 0, 1, 16'h0020, 32'hAB00, 4'b0010, dat);
    access(0, 0, 1, 0, 16'h0020, 32'h0, 4'b0, dat);
    chk("t2 masked write", dat, 32'h0000AB34);

    // 3: same-word write conflicts
    sync();
    start(0, 0, 0, 1, 16'h0030, 32'h1111, 4'b0011);
    start(0, 1, 0, 1, 16'h0030, 32'h2222, 4'b0011);
    wait_resp(0, 0, dat);
    sync();
    stop(0, 0); stop(0, 1);
    access(0, 0, 1, 0, 16'h0030, 32'h0, 4'b0, dat);
    chk("t3 full-mask conflict", dat, 32'h00001111);
    sync();
    start(0, 0, 0, 1, 16'h0030, 32'h1111, 4'b0001);
    start(0, 1, 0, 1, 16'h0030, 32'h2222, 4'b0011);
    wait_resp(0, 0, dat);
    sync();
    stop(0, 0); stop(0, 1);
    access(0, 1, 1, 0, 16'h0030, 32'h0, 4'b0, dat);
    chk("t3 per-byte conflict", dat, 32'h00002211);

    // read on one port while the other writes the same word; then read+write
    sync();
    start(0, 0, 1, 0, 16'h0030, 32'h0, 4'b0000);
    start(0, 1, 0, 1, 16'h0030, 32'h5555, 4'b0011);
    wait_resp(0, 0, dat);
    sync();
    stop(0, 0); stop(0, 1);
    chk("t3 read vs write old data", dat, 32'h00002211);
    access(0, 0, 1, 1, 16'h0030, 32'h7777, 4'b0011, dat);
    chk("t3 read+write pre-write", dat, 32'h00005555);
    access(0, 0, 1, 0, 16'h0030, 32'h0, 4'b0, dat);
    chk("t3 read+write committed", dat, 32'h00007777);

    // 4: 32-bit, 3 ports, latency 4
    access(1, 0, 0, 1, 16'h0100, 32'hDEADBEEF, 4'b1111, dat);
    access(1, 1, 0, 1, 16'h0102, 32'h11223344, 4'b0101, dat);
    access(1, 2, 1, 0, 16'h0100, 32'h0, 4'b0, dat);
    chk("t4 32b masked write", dat, 32'hDE22BE44);
    sync();
    start(1, 0, 1, 0, 16'h0100, 32'h0, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t4 held read resp k=%0d", k), 32'(b_resp[0]), 32'(k == 4 || k == 9));
      if (k == 4 || k == 9) chk($sformatf("t4 held read data k=%0d", k), b_rdata[0], 32'hDE22BE44);
      sync();
    end
    stop(1, 0);
    sync();
    start(1, 0, 0, 1, 16'h0200, 32'hAAAAAAAA, 4'b0001);
    start(1, 1, 0, 1, 16'h0200, 32'hBBBBBBBB, 4'b0011);
    start(1, 2, 0, 1, 16'h0200, 32'hCCCCCCCC, 4'b1111);
    wait_resp(1, 0, dat);
    sync();
    stop(1, 0); stop(1, 1); stop(1, 2);
    access(1, 2, 1, 0, 16'h0200, 32'h0, 4'b0, dat);
    chk("t4 3-port priority", dat, 32'hCCCCBBAA);

    // 6: address changed while waiting
    sync();
    start(2, 0, 0, 1, 16'h0050, 32'h0102, 4'b0011);
    sync();
    ad_v[2][0] = 16'h0052;
    wait_resp(2, 0, dat);
    sync();
    stop(2, 0);
    sync();
    @(negedge clk);
    chk("t6 proto_err set", 32'(c_err[0]), 32'(CHK));
    access(2, 0, 1, 0, 16'h0050, 32'h0, 4'b0, dat);
    chk("t6 latched address used", dat, 32'h00000102);
    chk("t6 proto_err held", 32'(c_err[0]), 32'(CHK));

    // 5: reset during WAIT aborts the write
    access(2, 0, 0, 1, 16'h0040, 32'h5A5A, 4'b0011, dat);
    access(2, 0, 1, 0, 16'h0040, 32'h0, 4'b0, dat);
    chk("t5 pre-write", dat, 32'h00005A5A);
    sync();
    start(2, 0, 0, 1, 16'h0040, 32'hFFFF, 4'b0011);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    stop(2, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t5 no resp k=%0d", k), 32'(c_resp[0]), 32'd0);
      if (k == 0) begin
        chk("t5 rdata cleared", 32'(c_rdata[0]), 32'd0);
        chk("t5 proto_err cleared", 32'(c_err[0]), 32'd0);
      end
    end
    access(2, 0, 1, 0, 16'h0040, 32'h0, 4'b0, dat);
    chk("t5 word unchanged", dat, 32'h00005A5A);

    repeat (3) sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
